tc_fast_ram: RTL and testbench
==============================

// Module: tc_fast_ram
// PURPOSE
// - Single-port word RAM for the TC component library; one clock, synchronous write, combinational ("fast") read.
// - Sits on the CPU data/program bus; the core issues load/save with a 16-bit address.
// - Read data is valid in the same cycle as load; writes commit on the rising clock edge.
// PARAMETERS
// - DATA_W  16   width of each word and of in0/out0
// - ADDR_W  16   width of the address port
// - DEPTH   256  number of stored words; power of two, 2 <= DEPTH <= 2**ADDR_W
// PORTS
// - clk      in   1       clock; all state changes on the rising edge
// - rst      in   1       reset; asynchronous, active-high
// - load     in   1       read enable
// - save     in   1       write enable
// - address  in   ADDR_W  word address
// - in0      in   DATA_W  write data
// - out0     out  DATA_W  read data
// BEHAVIOUR
// - Storage: DEPTH x DATA_W register array.
// - Index = address[log2(DEPTH)-1:0]; upper address bits are ignored, so addresses alias modulo DEPTH (0x0100 == 0x0000 at DEPTH=256).
// - Write: at posedge clk with save=1 and rst=0, mem[index] <= in0.
// - Write latency: 1 edge; no write occurs when save=0.
// - Read: out0 = mem[index] combinationally while load=1 and rst=0.
// - Read latency: 0 cycles; out0 follows address changes within the same cycle.
// - out0 = 0 whenever load=0 or rst=1; no X or stale value is ever driven.
// - Read during write, same address, load=1 and save=1:
//   - out0 shows the old word until the edge.
//   - out0 shows in0 after the edge (write-first is not supported).
// - Reset, asynchronous and active-high:
//   - out0 is forced to 0 immediately.
//   - Writes are blocked while rst=1, including a save that coincides with rst rising mid-cycle.
//   - Memory content on reset depends on the macro (see CONFIGURATION).
// - No handshake; load and save are level-sensitive and sampled every cycle.
// - load=save=1 is legal and gives the read-during-write behaviour above.
// - Power-up: the simulation model initialises every word to 0.
// CONFIGURATION
// - Macro TC_FASTRAM_CLEAR_ON_RESET_EN, defined:
//   - Asserting rst asynchronously clears every word to 0.
//   - Contents read 0 on the first cycle after rst deasserts.
// - Macro TC_FASTRAM_CLEAR_ON_RESET_EN, undefined:
//   - rst affects only out0 and the write path.
//   - Stored contents persist across reset (warm reset keeps program/data).
// TESTING
// - rst=1 for 10 cycles, load=1 addr=0 -> out0=0x0000; write attempted during rst is not stored.
// - save=1 addr=0x0000 in0=0x0001 for one edge; then load=1 addr=0x0000 -> out0=0x0001 same cycle; load=0 -> out0=0x0000.
// - save addr=0x0001 in0=0x0002, load addr=0x0001 -> 0x0002; then load addr=0x0000 -> still 0x0001 (no cross-write).
// - load=1 save=1 addr=0x0005 old=0x1234 in0=0xBEEF -> out0=0x1234 before the edge, 0xBEEF after the edge.
// - DEPTH=256: save addr=0x0100 in0=0x00AA, load addr=0x0000 -> 0x00AA (alias check).
// - Write 0x5555 at addr 3, pulse rst mid-cycle -> 0x0000 with macro defined, 0x5555 without.

Source files
------------

// File: rtl/tc_fast_ram.sv
// Single-port word RAM: synchronous write, combinational read gated by load.
// Optional macro TC_FASTRAM_CLEAR_ON_RESET_EN: rst asynchronously clears every word.
module tc_fast_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              save,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] in0,
    output logic [DATA_W-1:0] out0
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Power-up value of every word is zero; the declaration initialiser carries it.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
    logic [IDX_W-1:0]  idx;

    // Upper address bits are ignored, so addresses alias modulo DEPTH.
    assign idx = address[IDX_W-1:0];

    generate
        if (IDX_W < ADDR_W) begin : g_unused_addr
            logic unused_addr_hi;
            assign unused_addr_hi = ^address[ADDR_W-1:IDX_W];
        end
    endgenerate

`ifdef TC_FASTRAM_CLEAR_ON_RESET_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (save) begin
            mem_q[idx] <= in0;
        end
    end
`else
    // Contents survive reset; rst only blocks the write path.
    always_ff @(posedge clk) begin
        if (save && !rst) begin
            mem_q[idx] <= in0;
        end
    end
`endif

    assign out0 = (load && !rst) ? mem_q[idx] : '0;

endmodule

// File: tb/tb_tc_fast_ram.sv
// Self-checking bench for tc_fast_ram: array reference model checked every
// negedge, plus directed literal expectations from hand-computed vectors.
module tb_tc_fast_ram;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              load;
    logic              save;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] in0;
    logic [DATA_W-1:0] out0;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] model [DEPTH] = '{default: '0};

    tc_fast_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .save    (save),
        .address (address),
        .in0     (in0),
        .out0    (out0)
    );

    always #5 clk = ~clk;

    // Reference: a write happens at a clock edge only when rst is low.
    always @(posedge clk) begin
        if (!rst && save) model[int'(address) % DEPTH] = in0;
    end

`ifdef TC_FASTRAM_CLEAR_ON_RESET_EN
    always @(posedge rst) begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    end
`endif

    function automatic logic [DATA_W-1:0] model_out();
        if (load && !rst) return model[int'(address) % DEPTH];
        return '0;
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: out0=%h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) chk("cycle", out0, model_out());

    task automatic drive(input logic r, input logic l, input logic s,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        rst = r; load = l; save = s; address = a; in0 = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset for 10 cycles with a write attempt that must not land.
        drive(1'b1, 1'b1, 1'b1, 16'h0000, 16'hDEAD);
        repeat (10) tick();
        #1 chk("rst_out0", out0, 16'h0000);
        tick();
        drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
        #1 chk("rst_write_blocked", out0, 16'h0000);

        // Basic write then same-cycle read, and load gating.
        tick();
        drive(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001);
        tick();
        drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
        #1 chk("read_addr0", out0, 16'h0001);
        load = 1'b0;
        #1 chk("load_off", out0, 16'h0000);

        // Second word, no cross-write.
        tick();
        drive(1'b0, 1'b0, 1'b1, 16'h0001, 16'h0002);
        tick();
        drive(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000);
        #1 chk("read_addr1", out0, 16'h0002);
        address = 16'h0000;
        #1 chk("no_cross_write", out0, 16'h0001);

        // Read during write on the same address.
        tick();
        drive(1'b0, 1'b0, 1'b1, 16'h0005, 16'h1234);
        tick();
        drive(1'b0, 1'b1, 1'b1, 16'h0005, 16'hBEEF);
        #1 chk("rdw_before_edge", out0, 16'h1234);
        tick();
        chk("rdw_after_edge", out0, 16'hBEEF);
        save = 1'b0;

        // Aliasing modulo DEPTH.
        tick();
        drive(1'b0, 1'b0, 1'b1, 16'h0100, 16'h00AA);
        tick();
        drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
        #1 chk("alias_0000", out0, 16'h00AA);
        address = 16'hFF00;
        #1 chk("alias_FF00", out0, 16'h00AA);

        // Pattern sweep across aliased addresses; checked by the model each cycle.
        for (int i = 0; i < 8; i++) begin
            tick();
            drive(1'b0, 1'b1, 1'b1, 16'(16'h0200 + i * 37), 16'(i * 16'h1357 + 1));
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            drive(1'b0, 1'b1, 1'b0, 16'(i * 37), 16'h0000);
        end
        tick();
        drive(1'b0, 1'b1, 1'b0, 16'd74, 16'h0000);
        #1 chk("sweep_i2", out0, 16'h26AF);

        // save coinciding with rst rising mid-cycle is blocked.
        tick();
        drive(1'b0, 1'b1, 1'b1, 16'h0007, 16'h7777);
        #1 rst = 1'b1;
        #1 chk("rst_forces_zero", out0, 16'h0000);
        tick();
        drive(1'b0, 1'b1, 1'b0, 16'h0007, 16'h0000);
        #1 chk("rst_blocks_save", out0, 16'h0000);

        // Warm reset pulse mid-cycle after writing 0x5555 at address 3.
        tick();
        drive(1'b0, 1'b0, 1'b1, 16'h0003, 16'h5555);
        tick();
        drive(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000);
        #1 chk("pre_pulse", out0, 16'h5555);
        rst = 1'b1;
        #1 chk("pulse_out0", out0, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        #1;
`ifdef TC_FASTRAM_CLEAR_ON_RESET_EN
        chk("post_pulse", out0, 16'h0000);
`else
        chk("post_pulse", out0, 16'h5555);
`endif

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
